sr_latch_driver: RTL and testbench



---
 rtl/sr_ctrl_pkg.sv | 14 +
 rtl/sr_debounce.sv | 60 ++++++
 rtl/sr_latch_driver.sv | 127 ++++++++++++
 tb/tb_sr_latch_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and default timing constants for the S_R latch control slice.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SET_PULSE = 2'd1,
      RST_PULSE = 2'd2,
      GAP       = 2'd3
   } sr_state_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
   localparam int unsigned PULSE_CYCLES_DEF    = 3;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, saturating debounce counter and rising-edge detect
// for one raw push-button input.
module sr_debounce
   import sr_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

   logic          sync_ff1;
   logic          sync_ff2;
   logic          level_q;
   logic [CW-1:0] cnt;

   // Metastability filter for the asynchronous button
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_ff1 <= 1'b0;
         sync_ff2 <= 1'b0;
      end else begin
         sync_ff1 <= raw;
         sync_ff2 <= sync_ff1;
      end
   end

   // Level follows the synchronised input only after it has disagreed for a full run;
   // the counter stops at CNT_DONE, so it cannot wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync_ff2 == level) begin
         cnt   <= '0;
      end else if (cnt == CNT_DONE) begin
         level <= sync_ff2;
         cnt   <= '0;
      end else begin
         cnt   <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns debounced set/reset button presses into fixed-width active-low pulses
// for an S_R latch, reset winning over set and never driving both low.
module sr_latch_driver
   import sr_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic set_btn,
   input  logic reset_btn,
   output logic Sbar,
   output logic Rbar,
   output logic busy
);

   localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

   sr_state_t     state;
   sr_state_t     next_state;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_next_c;
   logic          set_pend;
   logic          rst_pend;
   logic          set_level;
   logic          set_rise;
   logic          rst_level;
   logic          rst_rise;
   logic          set_req_c;
   logic          rst_req_c;
   logic          set_start_c;
   logic          rst_start_c;
   logic          sbar_c;
   logic          rbar_c;
   logic          busy_c;

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (set_btn),
      .level (set_level),
      .rise  (set_rise)
   );

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (reset_btn),
      .level (rst_level),
      .rise  (rst_rise)
   );

   assign set_req_c = set_rise & set_level;
   assign rst_req_c = rst_rise & rst_level;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: GAP re-arbitrates directly so back-to-back pulses are PULSE_CYCLES+1 apart
   always_comb begin
      next_state = state;
      case (state)
         IDLE, GAP: begin
            if (rst_pend || rst_req_c) begin
               next_state = RST_PULSE;
            end else if (set_pend || set_req_c) begin
               next_state = SET_PULSE;
            end else begin
               next_state = IDLE;
            end
         end
         SET_PULSE, RST_PULSE: begin
            if (pcnt == PULSE_LAST) begin
               next_state = GAP;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Pulse bookkeeping and next output values
   always_comb begin
      set_start_c = (next_state == SET_PULSE) && (state != SET_PULSE);
      rst_start_c = (next_state == RST_PULSE) && (state != RST_PULSE);
      pcnt_next_c = '0;
      if ((state == SET_PULSE || state == RST_PULSE) && next_state == state) begin
         pcnt_next_c = pcnt + PW'(1);
      end
      sbar_c = (next_state != SET_PULSE);
      rbar_c = (next_state != RST_PULSE);
      busy_c = (next_state != IDLE);
   end

   // Pending flags merge repeat requests and drop when their pulse begins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set_pend <= 1'b0;
         rst_pend <= 1'b0;
         pcnt     <= '0;
      end else begin
         set_pend <= (set_pend | set_req_c) & ~set_start_c;
         rst_pend <= (rst_pend | rst_req_c) & ~rst_start_c;
         pcnt     <= pcnt_next_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Sbar <= 1'b1;
         Rbar <= 1'b1;
         busy <= 1'b0;
      end else begin
         Sbar <= sbar_c;
         Rbar <= rbar_c;
         busy <= busy_c;
      end
   end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with default parameters; edge numbers are
// counted from the first rising clock edge after a raw input change.
module tb_sr_latch_driver;

   logic clk = 1'b0;
   logic rst;
   logic set_btn;
   logic reset_btn;
   logic Sbar;
   logic Rbar;
   logic busy;

   int tests = 0;
   int fails = 0;

   sr_latch_driver dut (
      .clk       (clk),
      .rst       (rst),
      .set_btn   (set_btn),
      .reset_btn (reset_btn),
      .Sbar      (Sbar),
      .Rbar      (Rbar),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] exp;
      rst = 1'b1; set_btn = 1'b1; reset_btn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if ({Sbar, Rbar, busy} !== 3'b110) begin
            fails++;
            $display("FAIL reset_hold cycle %0d: SRB got %b want 110", i, {Sbar, Rbar, busy});
         end
      end
      rst = 1'b0;
      for (int e = 0; e < 16; e++) begin
         step();
         exp[2] = !(e >= 11 && e <= 13);
         exp[1] = !(e >= 7 && e <= 9);
         exp[0] = (e >= 7 && e <= 14);
         tests++;
         if ({Sbar, Rbar, busy} !== exp) begin
            fails++;
            $display("FAIL reset_release edge %0d: SRB got %b want %b", e, {Sbar, Rbar, busy}, exp);
         end
      end
      set_btn = 1'b0; reset_btn = 1'b0;
      repeat (20) step();
   endtask

   task automatic test_clean_set();
      logic [2:0] exp;
      set_btn = 1'b1;
      for (int e = 0; e < 20; e++) begin
         step();
         exp[2] = !(e >= 7 && e <= 9);
         exp[1] = 1'b1;
         exp[0] = (e >= 7 && e <= 10);
         tests++;
         if ({Sbar, Rbar, busy} !== exp) begin
            fails++;
            $display("FAIL clean_set edge %0d: SRB got %b want %b", e, {Sbar, Rbar, busy}, exp);
         end
      end
      set_btn = 1'b0;
      repeat (20) step();
   endtask

   task automatic test_glitch();
      set_btn = 1'b1;
      step();
      step();
      set_btn = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         tests++;
         if ({Sbar, Rbar, busy} !== 3'b110) begin
            fails++;
            $display("FAIL glitch cycle %0d: SRB got %b want 110", i, {Sbar, Rbar, busy});
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] exp;
      set_btn = 1'b1; reset_btn = 1'b1;
      for (int e = 0; e < 18; e++) begin
         step();
         exp[2] = !(e >= 11 && e <= 13);
         exp[1] = !(e >= 7 && e <= 9);
         exp[0] = (e >= 7 && e <= 14);
         tests++;
         if ({Sbar, Rbar, busy} !== exp || (Sbar | Rbar) !== 1'b1) begin
            fails++;
            $display("FAIL simultaneous edge %0d: SRB got %b want %b", e, {Sbar, Rbar, busy}, exp);
         end
      end
      set_btn = 1'b0; reset_btn = 1'b0;
      repeat (20) step();
   endtask

   task automatic test_queued();
      logic [2:0] exp;
      for (int e = 0; e < 40; e++) begin
         if (e == 0)  set_btn = 1'b1;
         if (e == 2)  reset_btn = 1'b1;
         if (e == 12) reset_btn = 1'b0;
         if (e == 14) reset_btn = 1'b1;
         step();
         exp[2] = !(e >= 7 && e <= 9);
         exp[1] = !(e >= 11 && e <= 13);
         exp[0] = (e >= 7 && e <= 14);
         tests++;
         if ({Sbar, Rbar, busy} !== exp) begin
            fails++;
            $display("FAIL queued edge %0d: SRB got %b want %b", e, {Sbar, Rbar, busy}, exp);
         end
      end
      set_btn = 1'b0; reset_btn = 1'b0;
      repeat (25) step();
   endtask

   task automatic test_async_reset();
      set_btn = 1'b1;
      for (int e = 0; e <= 8; e++) step();
      tests++;
      if ({Sbar, Rbar, busy} !== 3'b011) begin
         fails++;
         $display("FAIL async_pre edge 8: SRB got %b want 011", {Sbar, Rbar, busy});
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({Sbar, Rbar, busy} !== 3'b110) begin
         fails++;
         $display("FAIL async_immediate: SRB got %b want 110", {Sbar, Rbar, busy});
      end
      set_btn = 1'b0;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         tests++;
         if ({Sbar, Rbar, busy} !== 3'b110) begin
            fails++;
            $display("FAIL async_after cycle %0d: SRB got %b want 110", i, {Sbar, Rbar, busy});
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      set_btn = 1'b0;
      reset_btn = 1'b0;
      test_reset();
      test_clean_set();
      test_glitch();
      test_simultaneous();
      test_queued();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
